rtc_alarm_bank: RTL and testbench

Parametrised BCD time-of-day clock with a bank of independently armed HH:MM alarms, the successor to the single-alarm board clock. It divides the system clock to a 1 Hz tick, keeps HH:MM:SS in BCD (24 h), accepts validated register-style writes for the time and each alarm, and raises a per-alarm pending flag that holds until acknowledged or a ring timeout expires. Outputs feed the existing seven-segment decoders and board LEDs directly.

---
 rtl/rtc_pkg.sv | 31 +++
 rtl/rtc_alarm_slot.sv | 78 +++++++
 rtl/rtc_alarm_bank.sv | 156 +++++++++++++++
 tb/tb_rtc_alarm_bank.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared types and helpers for the BCD time-of-day clock.
//   bcd_t       : one 4-bit BCD digit
//   hhmm_t      : packed {hour_t, hour_u, min_t, min_u}, the same layout as the wr_data[15:0] field
//   hhmm_valid(): true when the value is a legal 24 h HH:MM in BCD
package rtc_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t hour_t;
    bcd_t hour_u;
    bcd_t min_t;
    bcd_t min_u;
  } hhmm_t;

  localparam bcd_t MAX_HOUR_T      = 4'd2;
  localparam bcd_t MAX_HOUR_U_AT_2 = 4'd3;
  localparam bcd_t MAX_MIN_T       = 4'd5;

  function automatic logic hhmm_valid(input hhmm_t v);
    logic ok;
    ok = (v.hour_t <= MAX_HOUR_T) && (v.hour_u <= 4'd9) &&
         (v.min_t <= MAX_MIN_T) && (v.min_u <= 4'd9);
    // Once the tens digit is 2, the units digit is limited to 0-3.
    if ((v.hour_t == MAX_HOUR_T) && (v.hour_u > MAX_HOUR_U_AT_2)) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/rtc_alarm_slot.sv
// rtc_alarm_slot: one HH:MM alarm slot, holding the alarm time, the enable, the pending flag and a ring timeout counter.
//   clk, resetn      : clock and asynchronous active-low reset
//   wr_i             : load wr_hhmm_i / wr_enable_i into this slot
//   tick_i           : second advance that actually took effect
//   next_hhmm_i      : HH:MM that the time counter shows after this tick
//   next_sec_zero_i  : the seconds after this tick are 00
//   ack_i            : clear pending and the ring counter
//   pending_o        : ringing flag
module rtc_alarm_slot
  import rtc_pkg::*;
#(
  parameter int RING_SECS = 60
) (
  input  logic  clk,
  input  logic  resetn,
  input  logic  wr_i,
  input  hhmm_t wr_hhmm_i,
  input  logic  wr_enable_i,
  input  logic  tick_i,
  input  hhmm_t next_hhmm_i,
  input  logic  next_sec_zero_i,
  input  logic  ack_i,
  output logic  pending_o
);

  localparam int RW = (RING_SECS > 0) ? $clog2(RING_SECS + 1) : 1;

  hhmm_t         hhmm_q, hhmm_d;
  logic          enable_q, enable_d;
  logic          pending_q, pending_d;
  logic [RW-1:0] ring_q, ring_d;
  logic          fire;

  // The compare uses the registered slot value, so a write landing in the
  // same cycle as the tick does not affect this tick's fire decision.
  assign fire = tick_i && next_sec_zero_i && enable_q && (next_hhmm_i == hhmm_q);

  always_comb begin
    hhmm_d    = hhmm_q;
    enable_d  = enable_q;
    pending_d = pending_q;
    ring_d    = ring_q;
    if (wr_i) begin
      hhmm_d   = wr_hhmm_i;
      enable_d = wr_enable_i;
    end
    if (fire) begin
      pending_d = 1'b1;
      ring_d    = RW'(RING_SECS);
    end else if (ack_i) begin
      pending_d = 1'b0;
      ring_d    = '0;
    end else if (tick_i && pending_q && (ring_q != '0)) begin
      // A zero counter never decrements, so RING_SECS = 0 rings until ack.
      ring_d = ring_q - RW'(1);
      if (ring_q == RW'(1)) begin
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hhmm_q    <= '0;
      enable_q  <= 1'b0;
      pending_q <= 1'b0;
      ring_q    <= '0;
    end else begin
      hhmm_q    <= hhmm_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      ring_q    <= ring_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/rtc_alarm_bank.sv
// rtc_alarm_bank: BCD 24 h time-of-day clock with a bank of HH:MM alarms.
//   clk, resetn              : clock and asynchronous active-low reset
//   wr_en/wr_addr/wr_data    : register write (addr 0 = time, k = alarm slot k-1; wr_data[16] = enable)
//   wr_err                   : one-cycle pulse after a rejected write
//   ack                      : per-slot clear of alarm_pending
//   hour_t..sec_u            : current time, BCD digits
//   sec_tick                 : one-cycle pulse on every second advance
//   alarm_pending            : per-slot ringing flags
module rtc_alarm_bank
  import rtc_pkg::*;
#(
  parameter  int TICK_DIV  = 50_000_000,
  parameter  int N_ALARMS  = 4,
  parameter  int RING_SECS = 60,
  localparam int AW        = $clog2(N_ALARMS + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [16:0]         wr_data,
  output logic                wr_err,
  input  logic [N_ALARMS-1:0] ack,
  output logic [3:0]          hour_t,
  output logic [3:0]          hour_u,
  output logic [3:0]          min_t,
  output logic [3:0]          min_u,
  output logic [3:0]          sec_t,
  output logic [3:0]          sec_u,
  output logic                sec_tick,
  output logic [N_ALARMS-1:0] alarm_pending
);

  localparam int DW = $clog2(TICK_DIV);

  logic [DW-1:0] div_q, div_d;
  hhmm_t         hhmm_q, hhmm_d;
  bcd_t          sec_t_q, sec_t_d, sec_u_q, sec_u_d;
  logic          sec_tick_q, sec_tick_d;
  logic          wr_err_q, wr_err_d;

  hhmm_t adv_hhmm;
  bcd_t  adv_sec_t, adv_sec_u;
  hhmm_t wr_hhmm;
  logic  wr_valid, time_wr, wrap, tick_eff;

  assign wr_hhmm  = hhmm_t'(wr_data[15:0]);
  assign wr_valid = hhmm_valid(wr_hhmm) && (wr_addr <= AW'(N_ALARMS));
  assign time_wr  = wr_en && wr_valid && (wr_addr == '0);
  assign wrap     = (div_q == DW'(TICK_DIV - 1));
  // A time write in the wrap cycle swallows that second entirely.
  assign tick_eff = wrap && !time_wr;

  // Time one second after the current value, with BCD carries.
  always_comb begin
    adv_hhmm  = hhmm_q;
    adv_sec_t = sec_t_q;
    adv_sec_u = sec_u_q;
    if (sec_u_q != 4'd9) begin
      adv_sec_u = sec_u_q + 4'd1;
    end else begin
      adv_sec_u = 4'd0;
      if (sec_t_q != 4'd5) begin
        adv_sec_t = sec_t_q + 4'd1;
      end else begin
        adv_sec_t = 4'd0;
        if (hhmm_q.min_u != 4'd9) begin
          adv_hhmm.min_u = hhmm_q.min_u + 4'd1;
        end else begin
          adv_hhmm.min_u = 4'd0;
          if (hhmm_q.min_t != MAX_MIN_T) begin
            adv_hhmm.min_t = hhmm_q.min_t + 4'd1;
          end else begin
            adv_hhmm.min_t = 4'd0;
            if ((hhmm_q.hour_t == MAX_HOUR_T) && (hhmm_q.hour_u == MAX_HOUR_U_AT_2)) begin
              adv_hhmm.hour_t = 4'd0;
              adv_hhmm.hour_u = 4'd0;
            end else if (hhmm_q.hour_u == 4'd9) begin
              adv_hhmm.hour_u = 4'd0;
              adv_hhmm.hour_t = hhmm_q.hour_t + 4'd1;
            end else begin
              adv_hhmm.hour_u = hhmm_q.hour_u + 4'd1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    div_d      = div_q + DW'(1);
    hhmm_d     = hhmm_q;
    sec_t_d    = sec_t_q;
    sec_u_d    = sec_u_q;
    sec_tick_d = tick_eff;
    wr_err_d   = wr_en && !wr_valid;
    if (time_wr) begin
      div_d   = '0;
      hhmm_d  = wr_hhmm;
      sec_t_d = 4'd0;
      sec_u_d = 4'd0;
    end else if (wrap) begin
      div_d   = '0;
      hhmm_d  = adv_hhmm;
      sec_t_d = adv_sec_t;
      sec_u_d = adv_sec_u;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q      <= '0;
      hhmm_q     <= '0;
      sec_t_q    <= '0;
      sec_u_q    <= '0;
      sec_tick_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      div_q      <= div_d;
      hhmm_q     <= hhmm_d;
      sec_t_q    <= sec_t_d;
      sec_u_q    <= sec_u_d;
      sec_tick_q <= sec_tick_d;
      wr_err_q   <= wr_err_d;
    end
  end

  generate
    for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_slot
      rtc_alarm_slot #(
        .RING_SECS(RING_SECS)
      ) u_slot (
        .clk            (clk),
        .resetn         (resetn),
        .wr_i           (wr_en && wr_valid && (wr_addr == AW'(gi + 1))),
        .wr_hhmm_i      (wr_hhmm),
        .wr_enable_i    (wr_data[16]),
        .tick_i         (tick_eff),
        .next_hhmm_i    (adv_hhmm),
        .next_sec_zero_i((adv_sec_t == 4'd0) && (adv_sec_u == 4'd0)),
        .ack_i          (ack[gi]),
        .pending_o      (alarm_pending[gi])
      );
    end
  endgenerate

  assign hour_t   = hhmm_q.hour_t;
  assign hour_u   = hhmm_q.hour_u;
  assign min_t    = hhmm_q.min_t;
  assign min_u    = hhmm_q.min_u;
  assign sec_t    = sec_t_q;
  assign sec_u    = sec_u_q;
  assign sec_tick = sec_tick_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_rtc_alarm_bank.sv
// tb_rtc_alarm_bank: directed bench for rtc_alarm_bank with TICK_DIV=4, N_ALARMS=4, RING_SECS=3.
module tb_rtc_alarm_bank;

  localparam int TICK_DIV  = 4;
  localparam int N_ALARMS  = 4;
  localparam int RING_SECS = 3;
  localparam int AW        = $clog2(N_ALARMS + 1);

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic [16:0]         wr_data = '0;
  logic                wr_err;
  logic [N_ALARMS-1:0] ack = '0;
  logic [3:0]          hour_t, hour_u, min_t, min_u, sec_t, sec_u;
  logic                sec_tick;
  logic [N_ALARMS-1:0] alarm_pending;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc;

  rtc_alarm_bank #(
    .TICK_DIV (TICK_DIV),
    .N_ALARMS (N_ALARMS),
    .RING_SECS(RING_SECS)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .ack          (ack),
    .hour_t       (hour_t),
    .hour_u       (hour_u),
    .min_t        (min_t),
    .min_u        (min_u),
    .sec_t        (sec_t),
    .sec_u        (sec_u),
    .sec_tick     (sec_tick),
    .alarm_pending(alarm_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] now_time();
    return {8'h00, hour_t, hour_u, min_t, min_u, sec_t, sec_u};
  endfunction

  // Called at a negedge; the write is sampled on the next posedge and the
  // task returns on the following negedge.
  task automatic do_write(input int addr, input logic [16:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    $display("[TB] write addr=%0d data=%05h -> wr_err=%0b time=%06h", addr, data, wr_err, now_time());
  endtask

  // Waits for the next sec_tick, returning the number of negedges it took.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sec_tick && n < 3 * TICK_DIV);
    if (!sec_tick) check("tick_timeout", 32'(sec_tick), 32'd1);
  endtask

  task automatic wait_ticks(input int count);
    int n;
    for (int i = 0; i < count; i++) wait_tick(n);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_time", now_time(), 32'h000000);
    check("rst_tick", 32'(sec_tick), 32'd0);
    check("rst_err", 32'(wr_err), 32'd0);
    check("rst_pend", 32'(alarm_pending), 32'd0);
    resetn = 1'b1;

    // Time write 23:59, tick period and wrap
    do_write(0, 17'h02359);
    check("tw_time", now_time(), 32'h235900);
    check("tw_err", 32'(wr_err), 32'd0);
    wait_tick(cyc);
    check("first_tick_lat", 32'(cyc), 32'd4);
    check("first_tick_time", now_time(), 32'h235901);
    @(negedge clk);
    check("tick_pulse_low", 32'(sec_tick), 32'd0);
    wait_tick(cyc);
    check("tick_period", 32'(cyc + 1), 32'd4);
    check("time_235902", now_time(), 32'h235902);
    wait_ticks(57);
    check("time_235959", now_time(), 32'h235959);
    wait_tick(cyc);
    check("wrap_000000", now_time(), 32'h000000);
    $display("[TB] wrap reached time=%06h", now_time());

    // Rejected writes
    do_write(0, 17'h02500);
    check("err_hour25", 32'(wr_err), 32'd1);
    check("err_hour25_time", now_time(), 32'h000000);
    do_write(0, 17'h01260);
    check("err_min60", 32'(wr_err), 32'd1);
    do_write(N_ALARMS + 1, 17'h01200);
    check("err_addr", 32'(wr_err), 32'd1);
    check("err_addr_time", now_time(), 32'h000000);
    @(negedge clk);
    check("err_clear", 32'(wr_err), 32'd0);
    check("err_tick_time", now_time(), 32'h000001);

    // Fire: slot0 00:01 enabled, slot1 00:01 disabled
    do_write(1, 17'h10001);
    do_write(2, 17'h00001);
    do_write(0, 17'h00000);
    wait_ticks(59);
    check("pre_fire_time", now_time(), 32'h000059);
    check("pre_fire_pend", 32'(alarm_pending), 32'd0);
    wait_tick(cyc);
    check("fire_time", now_time(), 32'h000100);
    check("fire_pend", 32'(alarm_pending), 32'b0001);
    $display("[TB] fire time=%06h pending=%04b", now_time(), alarm_pending);

    // Ring timeout after three ticks
    wait_tick(cyc);
    check("ring_t1", 32'(alarm_pending), 32'b0001);
    wait_tick(cyc);
    check("ring_t2", 32'(alarm_pending), 32'b0001);
    wait_tick(cyc);
    check("ring_t3", 32'(alarm_pending), 32'b0000);

    // Fire wins over a same-cycle ack
    do_write(0, 17'h00000);
    wait_ticks(59);
    repeat (3) @(negedge clk);
    ack = 4'b0001;
    @(negedge clk);
    ack = '0;
    check("fw_tick", 32'(sec_tick), 32'd1);
    check("fw_time", now_time(), 32'h000100);
    check("fw_pend", 32'(alarm_pending), 32'b0001);
    do_write(1, 17'h00001);
    check("disable_keeps", 32'(alarm_pending), 32'b0001);
    ack = 4'b0001;
    @(negedge clk);
    ack = '0;
    check("ack_clear", 32'(alarm_pending), 32'b0000);

    // Time write onto a match never fires
    do_write(3, 17'h11235);
    do_write(1, 17'h10001);
    do_write(0, 17'h00001);
    check("tw_match_time", now_time(), 32'h000100);
    check("tw_match_pend", 32'(alarm_pending), 32'd0);

    // Time write coincident with the divider wrap
    repeat (3) @(negedge clk);
    do_write(0, 17'h01234);
    check("tw_wrap_time", now_time(), 32'h123400);
    check("tw_wrap_tick", 32'(sec_tick), 32'd0);
    wait_tick(cyc);
    check("tw_wrap_restart", 32'(cyc), 32'd4);
    check("tw_wrap_next", now_time(), 32'h123401);

    // Slot 2 fires at 12:35, then reset mid-ring
    wait_ticks(59);
    check("slot2_time", now_time(), 32'h123500);
    check("slot2_pend", 32'(alarm_pending), 32'b0100);
    resetn = 1'b0;
    #1;
    check("arst_time", now_time(), 32'h000000);
    check("arst_pend", 32'(alarm_pending), 32'd0);
    check("arst_tick", 32'(sec_tick), 32'd0);
    check("arst_err", 32'(wr_err), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    $display("[TB] reset released time=%06h", now_time());

    // Slots are disabled after reset: 12:35 must not fire again
    do_write(0, 17'h01234);
    wait_ticks(60);
    check("post_rst_time", now_time(), 32'h123500);
    check("post_rst_pend", 32'(alarm_pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
